multicycle_ctrl: RTL and testbench

Multi-cycle control unit for the single-ALU CPU datapath. Sequences each instruction through fetch, decode, execute, memory and write-back. Drives the ALU opcode, the ALU A/B operand muxes, the register-file and PC write enables, and the memory request handshake. Sits beside the datapath and consumes only the instruction opcode, the ALU `zero` flag and the memory ready signal.

---
 rtl/cpu_pkg.sv | 53 +++++
 rtl/mem_wait_counter.sv | 37 +++
 rtl/multicycle_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared opcode/ALU codes, operand-B encodings and controller state type.
// MULTICYCLE_CTRL_BEQ_EN adds the BEQ opcode and the BRANCH state.
package cpu_pkg;

    // Opcodes double as ALU control codes for the R-type group.
    localparam logic [3:0] OpMov  = 4'b0000;
    localparam logic [3:0] OpNot  = 4'b0001;
    localparam logic [3:0] OpAdd  = 4'b0010;
    localparam logic [3:0] OpSub  = 4'b0011;
    localparam logic [3:0] OpOr   = 4'b0100;
    localparam logic [3:0] OpAnd  = 4'b0101;
    localparam logic [3:0] OpSlt  = 4'b0111;
    localparam logic [3:0] OpLi   = 4'b1001;
    localparam logic [3:0] OpLw   = 4'b1010;
    localparam logic [3:0] OpSw   = 4'b1011;
    localparam logic [3:0] OpBeq  = 4'b1100;
    localparam logic [3:0] OpHalt = 4'b1111;

    localparam logic [3:0] AluAdd = OpAdd;
    localparam logic [3:0] AluSub = OpSub;
    localparam logic [3:0] AluLi  = OpLi;

    localparam logic [1:0] SrcBReg = 2'b00;
    localparam logic [1:0] SrcBOne = 2'b01;
    localparam logic [1:0] SrcBImm = 2'b10;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StFetch  = 3'd1,
        StDecode = 3'd2,
        StExec   = 3'd3,
        StMem    = 3'd4,
        StWb     = 3'd5,
`ifdef MULTICYCLE_CTRL_BEQ_EN
        StBranch = 3'd6,
`endif
        StHalt   = 3'd7
    } state_e;

    function automatic logic is_rtype(logic [3:0] op);
        return op inside {OpMov, OpNot, OpAdd, OpSub, OpOr, OpAnd, OpSlt};
    endfunction

    function automatic logic is_legal(logic [3:0] op);
        logic legal;
        legal = is_rtype(op) || (op inside {OpLi, OpLw, OpSw, OpHalt});
`ifdef MULTICYCLE_CTRL_BEQ_EN
        if (op == OpBeq) legal = 1'b1;
`endif
        return legal;
    endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// Memory wait counter: counts cycles without mem_ready and flags the last allowed one.
// MAX = 0 disables the limit (expired never asserts).
module mem_wait_counter #(
    parameter int unsigned MAX = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic inc,
    output logic expired
);

    localparam int unsigned W = (MAX > 1) ? $clog2(MAX) : 1;

    logic [W-1:0] cnt_q, cnt_d;

    // Expired marks the MAX-th waiting cycle, so the count never needs to exceed MAX-1.
    assign expired = (MAX != 0) && (cnt_q == W'(MAX - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (inc && !expired) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the single-ALU datapath (fetch/decode/exec/mem/wb).
// MULTICYCLE_CTRL_BEQ_EN enables BEQ decoding and the BRANCH state.
module multicycle_ctrl
    import cpu_pkg::*;
#(
    parameter int unsigned IMEM_WAIT_MAX = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [3:0] alu_op,
    output logic       illegal,
    output logic       halted,
    output logic       timeout
);

    state_e     state_q, state_d;
    logic [3:0] opcode_q;
    logic       waiting;
    logic       wait_expired;
    logic       timeout_hit;
    logic       wait_clear;

`ifndef MULTICYCLE_CTRL_BEQ_EN
    logic unused_zero;
    assign unused_zero = zero;
`endif

    assign waiting     = ((state_q == StFetch) || (state_q == StMem)) && !mem_ready;
    assign timeout_hit = waiting && wait_expired;
    // Any state change, or a timeout re-entering FETCH, starts a fresh wait window.
    assign wait_clear  = (state_d != state_q) || timeout_hit;

    mem_wait_counter #(
        .MAX (IMEM_WAIT_MAX)
    ) u_wait_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (wait_clear),
        .inc     (waiting),
        .expired (wait_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            opcode_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == StDecode) begin
                opcode_q <= opcode;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: state_d = StFetch;
            StFetch: begin
                if (mem_ready) begin
                    state_d = StDecode;
                end else if (timeout_hit) begin
                    state_d = StFetch;
                end
            end
            StDecode: begin
                if (!is_legal(opcode)) begin
                    state_d = StFetch;
                end else if (opcode == OpHalt) begin
                    state_d = StHalt;
                end else begin
                    state_d = StExec;
                end
            end
            StExec: begin
                if (is_rtype(opcode_q) || (opcode_q == OpLi)) begin
                    state_d = StWb;
                end else if ((opcode_q == OpLw) || (opcode_q == OpSw)) begin
                    state_d = StMem;
`ifdef MULTICYCLE_CTRL_BEQ_EN
                end else if (opcode_q == OpBeq) begin
                    state_d = zero ? StBranch : StFetch;
`endif
                end else begin
                    state_d = StFetch;
                end
            end
            StMem: begin
                if (mem_ready) begin
                    state_d = (opcode_q == OpLw) ? StWb : StFetch;
                end else if (timeout_hit) begin
                    state_d = StFetch;
                end
            end
            StWb: state_d = StFetch;
`ifdef MULTICYCLE_CTRL_BEQ_EN
            StBranch: state_d = StFetch;
`endif
            StHalt: state_d = StHalt;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        mem_req    = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SrcBReg;
        alu_op     = '0;
        illegal    = 1'b0;
        halted     = 1'b0;
        timeout    = 1'b0;
        unique case (state_q)
            StIdle: ;
            StFetch: begin
                mem_req   = 1'b1;
                mem_read  = 1'b1;
                alu_src_b = SrcBOne;
                alu_op    = AluAdd;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                timeout   = timeout_hit;
            end
            StDecode: illegal = !is_legal(opcode);
            StExec: begin
                alu_src_a = 1'b1;
                if (opcode_q == OpLi) begin
                    alu_op    = AluLi;
                    alu_src_b = SrcBImm;
                end else if ((opcode_q == OpLw) || (opcode_q == OpSw)) begin
                    alu_op    = AluAdd;
                    alu_src_b = SrcBImm;
                end else if (opcode_q == OpBeq) begin
                    alu_op    = AluSub;
                    alu_src_b = SrcBReg;
                end else begin
                    alu_op    = opcode_q;
                    alu_src_b = SrcBReg;
                end
            end
            StMem: begin
                // Address operands stay selected for the whole request.
                mem_req   = 1'b1;
                mem_read  = (opcode_q == OpLw);
                mem_write = (opcode_q == OpSw);
                alu_src_a = 1'b1;
                alu_src_b = SrcBImm;
                alu_op    = AluAdd;
                timeout   = timeout_hit;
            end
            StWb: begin
                reg_write  = 1'b1;
                mem_to_reg = (opcode_q == OpLw);
            end
`ifdef MULTICYCLE_CTRL_BEQ_EN
            StBranch: begin
                alu_src_b = SrcBImm;
                alu_op    = AluAdd;
                pc_write  = 1'b1;
            end
`endif
            StHalt: halted = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed steps plus random instruction streams.
// Expectations follow MULTICYCLE_CTRL_BEQ_EN the same way the design does.
module tb_multicycle_ctrl;

    localparam int unsigned WaitMax = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] opcode = 4'h0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_req, mem_read, mem_write, ir_write, pc_write, reg_write, mem_to_reg;
    logic       alu_src_a, illegal, halted, timeout;
    logic [1:0] alu_src_b;
    logic [3:0] alu_op;

    typedef struct packed {
        logic       mem_req;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       pc_write;
        logic       reg_write;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [3:0] alu_op;
        logic       illegal;
        logic       halted;
        logic       timeout;
    } outs_t;

    outs_t obs;
    int    n_checks = 0;
    int    n_fail = 0;

    assign obs = {mem_req, mem_read, mem_write, ir_write, pc_write, reg_write, mem_to_reg,
                  alu_src_a, alu_src_b, alu_op, illegal, halted, timeout};

    multicycle_ctrl #(
        .IMEM_WAIT_MAX (WaitMax)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .reg_write  (reg_write),
        .mem_to_reg (mem_to_reg),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .illegal    (illegal),
        .halted     (halted),
        .timeout    (timeout)
    );

    always #5 clk = ~clk;

    // ---------------- reference model: per-phase expected outputs ----------------
    function automatic bit legal(logic [3:0] op);
`ifdef MULTICYCLE_CTRL_BEQ_EN
        return op inside {4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h7, 4'h9, 4'hA, 4'hB,
                          4'hC, 4'hF};
`else
        return op inside {4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h7, 4'h9, 4'hA, 4'hB, 4'hF};
`endif
    endfunction

    function automatic outs_t o_fetch(logic rdy, logic tmo);
        outs_t o = '0;
        o.mem_req = 1'b1; o.mem_read = 1'b1; o.alu_src_b = 2'b01; o.alu_op = 4'b0010;
        o.ir_write = rdy; o.pc_write = rdy; o.timeout = tmo;
        return o;
    endfunction

    function automatic outs_t o_decode(logic [3:0] op);
        outs_t o = '0;
        o.illegal = !legal(op);
        return o;
    endfunction

    function automatic outs_t o_exec(logic [3:0] op);
        outs_t o = '0;
        o.alu_src_a = 1'b1;
        case (op)
            4'h9:       begin o.alu_op = 4'b1001; o.alu_src_b = 2'b10; end
            4'hA, 4'hB: begin o.alu_op = 4'b0010; o.alu_src_b = 2'b10; end
            4'hC:       begin o.alu_op = 4'b0011; o.alu_src_b = 2'b00; end
            default:    begin o.alu_op = op;      o.alu_src_b = 2'b00; end
        endcase
        return o;
    endfunction

    function automatic outs_t o_mem(logic [3:0] op, logic tmo);
        outs_t o = '0;
        o.mem_req = 1'b1; o.mem_read = (op == 4'hA); o.mem_write = (op == 4'hB);
        o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; o.alu_op = 4'b0010; o.timeout = tmo;
        return o;
    endfunction

    function automatic outs_t o_wb(logic is_lw);
        outs_t o = '0;
        o.reg_write = 1'b1; o.mem_to_reg = is_lw;
        return o;
    endfunction

    function automatic outs_t o_branch();
        outs_t o = '0;
        o.alu_src_b = 2'b10; o.alu_op = 4'b0010; o.pc_write = 1'b1;
        return o;
    endfunction

    function automatic outs_t o_halt();
        outs_t o = '0;
        o.halted = 1'b1;
        return o;
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [3:0] rop();
        return 4'($urandom_range(0, 15));
    endfunction

    // ---------------- drivers / checkers ----------------
    task automatic chk(input string tag, input outs_t exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic rdy, input logic [3:0] op, input logic z,
                        input outs_t exp, input string tag);
        @(negedge clk);
        mem_ready = rdy;
        opcode    = op;
        zero      = z;
        #1 chk(tag, exp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        mem_ready = 1'b1;
        #1 chk("reset_async", '0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            mem_ready = rb();
            opcode    = rop();
            #1 chk("reset_hold", '0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("idle", '0);
    endtask

    task automatic fetch_phase(input int fw);
        int k = 0;
        for (int i = 0; i < fw; i++) begin
            k++;
            if (k == WaitMax) begin
                step(1'b0, rop(), rb(), o_fetch(1'b0, 1'b1), "fetch_timeout");
                k = 0;
            end else begin
                step(1'b0, rop(), rb(), o_fetch(1'b0, 1'b0), "fetch_wait");
            end
        end
        step(1'b1, rop(), rb(), o_fetch(1'b1, 1'b0), "fetch_ready");
    endtask

    task automatic mem_phase(input logic [3:0] op, input int mw, output bit done);
        done = 1'b1;
        for (int i = 1; i <= mw; i++) begin
            if (i == WaitMax) begin
                step(1'b0, rop(), rb(), o_mem(op, 1'b1), "mem_timeout");
                done = 1'b0;
                return;
            end
            step(1'b0, rop(), rb(), o_mem(op, 1'b0), "mem_wait");
        end
        step(1'b1, rop(), rb(), o_mem(op, 1'b0), "mem_ready");
    endtask

    // One instruction from FETCH until control returns to FETCH (or HALT is reached).
    task automatic run_instr(input logic [3:0] op, input int fw, input int mw, input logic z);
        bit done;
        fetch_phase(fw);
        step(rb(), op, rb(), o_decode(op), "decode");
        if (!legal(op)) return;
        if (op == 4'hF) begin
            for (int i = 0; i < 20; i++) step(rb(), rop(), rb(), o_halt(), "halt");
            return;
        end
        step(rb(), rop(), z, o_exec(op), "exec");
        case (op)
            4'hA: begin
                mem_phase(op, mw, done);
                if (done) step(rb(), rop(), rb(), o_wb(1'b1), "wb_lw");
            end
            4'hB: mem_phase(op, mw, done);
            4'hC: if (z) step(rb(), rop(), rb(), o_branch(), "branch");
            default: step(rb(), rop(), rb(), o_wb(1'b0), "wb");
        endcase
    endtask

    initial begin
        logic [3:0] op;
        do_reset();
        // ADD with zero-wait memory
        run_instr(4'h2, 0, 0, 1'b0);
        // LW with three MEM wait cycles
        run_instr(4'hA, 0, 3, 1'b0);
        // BEQ taken and not taken
        run_instr(4'hC, 0, 0, 1'b1);
        run_instr(4'hC, 0, 0, 1'b0);
        // Illegal opcodes
        run_instr(4'h6, 0, 0, 1'b0);
        run_instr(4'h8, 1, 0, 1'b0);
        run_instr(4'hE, 0, 0, 1'b0);
        // LI, SW, R-type mix
        run_instr(4'h9, 2, 0, 1'b0);
        run_instr(4'hB, 0, 2, 1'b0);
        run_instr(4'h7, 0, 0, 1'b1);
        // Wait-limit expiry in FETCH (single and double) and in MEM
        run_instr(4'h2, 4, 0, 1'b0);
        run_instr(4'h3, 9, 0, 1'b0);
        run_instr(4'hB, 0, 4, 1'b0);
        run_instr(4'hA, 3, 4, 1'b0);
        // Reset during SW MEM aborts the store
        fetch_phase(0);
        step(rb(), 4'hB, rb(), o_decode(4'hB), "decode_sw");
        step(rb(), rop(), rb(), o_exec(4'hB), "exec_sw");
        step(1'b0, rop(), rb(), o_mem(4'hB, 1'b0), "mem_sw");
        do_reset();
        run_instr(4'h1, 0, 0, 1'b0);
        // HALT holds for 20 cycles whatever the inputs
        run_instr(4'hF, 0, 0, 1'b0);
        do_reset();
        // Random instruction stream
        for (int n = 0; n < 80; n++) begin
            op = rop();
            run_instr(op, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 9)) : 0,
                      int'($urandom_range(0, 5)), rb());
            if (op == 4'hF) do_reset();
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
